// File: rtl/aes_uart_pkg.sv
// Shared types and command-byte defaults for the AES UART controller.
package aes_uart_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RX_KEY = 3'd1,
    ST_RX_PT  = 3'd2,
    ST_RUN    = 3'd3,
    ST_TX     = 3'd4
  } state_e;

  localparam logic [7:0] CMD_KEY_DEF = 8'h4B;
  localparam logic [7:0] CMD_PT_DEF  = 8'h50;

endpackage

// File: rtl/aes_byte_shifter.sv
// 128-bit load/shift-by-byte register: new byte enters at [7:0], oldest byte sits at [127:120].
// Updates in one cycle; done flags the shift that completes 16 bytes, no backpressure of its own.
module aes_byte_shifter
  import aes_uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  block_t     load_dat,
  input  logic       shift_en,
  input  logic [7:0] shift_in,
  output block_t     dat,
  output logic       done
);

  block_t     data_q, data_d;
  logic [3:0] cnt_q, cnt_d;

  // clear beats load beats shift, so an abort always leaves an empty register
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clear) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (load) begin
      data_d = load_dat;
      cnt_d  = '0;
    end else if (shift_en) begin
      data_d = {data_q[119:0], shift_in};
      cnt_d  = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dat  = data_q;
  assign done = shift_en && (cnt_q == 4'hF);

endmodule

// File: rtl/aes_uart_ctrl.sv
// Sequences the AES core from UART bytes: 'K'+16 loads the key, 'P'+16 loads plaintext, runs the core, streams the cypher.
// tx_valid rises AES_LATENCY+1 cycles after the last plaintext byte; TX holds under tx_ready low, RX bytes in RUN/TX are dropped.
module aes_uart_ctrl
  import aes_uart_pkg::*;
#(
  parameter int         AES_LATENCY    = 12,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] CMD_KEY        = CMD_KEY_DEF,
  parameter logic [7:0] CMD_PT         = CMD_PT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  input  logic         tx_ready,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  output logic [127:0] aes_key,
  output logic [127:0] aes_plaintext,
  output logic         aes_enable,
  input  logic [127:0] aes_cypher,
  output logic         busy,
  output logic         key_loaded,
  output logic         frame_err,
  output logic         rx_drop
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(AES_LATENCY + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RUN_LAST = RW'(AES_LATENCY - 1);

  state_e        state_q, state_d;
  block_t        key_q, key_d;
  block_t        pt_q, pt_d;
  logic          key_loaded_q, key_loaded_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_drop_q, rx_drop_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;

  logic   stg_clear, stg_shift, stg_done;
  block_t stg_dat;
  logic   tx_load, tx_shift, tx_done;
  block_t tx_dat;
  logic   unused_bits;

  aes_byte_shifter u_stage (
    .clk      (clk),
    .reset    (reset),
    .clear    (stg_clear),
    .load     (1'b0),
    .load_dat ('0),
    .shift_en (stg_shift),
    .shift_in (rx_data),
    .dat      (stg_dat),
    .done     (stg_done)
  );

  aes_byte_shifter u_tx (
    .clk      (clk),
    .reset    (reset),
    .clear    (1'b0),
    .load     (tx_load),
    .load_dat (aes_cypher),
    .shift_en (tx_shift),
    .shift_in (8'h00),
    .dat      (tx_dat),
    .done     (tx_done)
  );

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    pt_d         = pt_q;
    key_loaded_d = key_loaded_q;
    frame_err_d  = 1'b0;
    rx_drop_d    = 1'b0;
    to_cnt_d     = '0;
    run_cnt_d    = run_cnt_q;
    stg_clear    = 1'b0;
    stg_shift    = 1'b0;
    tx_load      = 1'b0;
    tx_shift     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stg_clear = 1'b1;
        if (rx_valid) begin
          if (rx_data == CMD_KEY) begin
            state_d = ST_RX_KEY;
          end else if ((rx_data == CMD_PT) && key_loaded_q) begin
            state_d = ST_RX_PT;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      ST_RX_KEY, ST_RX_PT: begin
        if (rx_valid) begin
          stg_shift = 1'b1;
          // The 16th byte is committed together with the staged 15, so the
          // committed block is visible the cycle after the last byte.
          if (stg_done) begin
            stg_clear = 1'b1;
            if (state_q == ST_RX_KEY) begin
              key_d        = {stg_dat[119:0], rx_data};
              key_loaded_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              pt_d      = {stg_dat[119:0], rx_data};
              run_cnt_d = RUN_LAST;
              state_d   = ST_RUN;
            end
          end
        end else if (to_cnt_q == TO_LAST) begin
          frame_err_d = 1'b1;
          stg_clear   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TW'(1);
        end
      end

      ST_RUN: begin
        rx_drop_d = rx_valid;
        if (run_cnt_q == '0) begin
          tx_load = 1'b1;
          state_d = ST_TX;
        end else begin
          run_cnt_d = run_cnt_q - RW'(1);
        end
      end

      ST_TX: begin
        rx_drop_d = rx_valid;
        if (tx_ready) begin
          tx_shift = 1'b1;
          if (tx_done) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      pt_q         <= '0;
      key_loaded_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_drop_q    <= 1'b0;
      to_cnt_q     <= '0;
      run_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      key_loaded_q <= key_loaded_d;
      frame_err_q  <= frame_err_d;
      rx_drop_q    <= rx_drop_d;
      to_cnt_q     <= to_cnt_d;
      run_cnt_q    <= run_cnt_d;
    end
  end

  assign tx_valid      = (state_q == ST_TX);
  assign tx_data       = tx_dat[127:120];
  assign aes_enable    = (state_q == ST_RUN);
  assign busy          = (state_q != ST_IDLE);
  assign aes_key       = key_q;
  assign aes_plaintext = pt_q;
  assign key_loaded    = key_loaded_q;
  assign frame_err     = frame_err_q;
  assign rx_drop       = rx_drop_q;

  // Staging top byte and TX low bytes are never read directly.
  assign unused_bits = ^{stg_dat[127:120], tx_dat[119:0]};

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Scoreboard bench for aes_uart_ctrl: randomized frames, behavioural core model, decoupled monitor.
module tb_aes_uart_ctrl;
  import aes_uart_pkg::*;

  localparam int L = 12;
  localparam int T = 40;
  localparam logic [127:0] K0 = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] P0 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C0 = 128'hff0b844a0853bf7c6934ab4364148fb9;

  logic         clk = 1'b0;
  logic         reset, rx_valid, tx_ready, tx_valid, aes_enable, busy, key_loaded, frame_err, rx_drop;
  logic [7:0]   rx_data, tx_data;
  logic [127:0] aes_key, aes_plaintext, aes_cypher, noise;

  int cyc = 0, n_checks = 0, n_pass = 0, en_cnt = 0, en_total = 0;
  int tx_xfers = 0, last_xfer_cyc = 0, last_cyc = 0, expect_start = 0, pt_start = 0;
  bit stall_mode = 0;
  bit m_loaded = 0;
  logic [127:0] m_key = '0;
  logic [7:0] exp_tx[$];
  int exp_err[$];
  int exp_drop[$];

  aes_uart_ctrl #(.AES_LATENCY(L), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .aes_key(aes_key), .aes_plaintext(aes_plaintext), .aes_enable(aes_enable),
    .aes_cypher(aes_cypher), .busy(busy), .key_loaded(key_loaded),
    .frame_err(frame_err), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  // Core model: result is only meaningful on the last enable cycle, noise otherwise.
  function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] p);
    if (k == K0 && p == P0) return C0;
    return k ^ {p[63:0], p[127:64]} ^ 128'ha5a5_3c3c_0ff0_9669_5a5a_c3c3_f00f_6996;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    en_cnt <= aes_enable ? en_cnt + 1 : 0;
    noise  <= {$urandom, $urandom, $urandom, $urandom};
  end
  assign aes_cypher = (aes_enable && en_cnt == L - 1) ? core_model(aes_key, aes_plaintext) : noise;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: samples on the falling edge and pops the scoreboard queues.
  initial begin : monitor
    logic [7:0] held, e;
    bit stalled, prev_vld;
    int en_run, c;
    stalled = 0; prev_vld = 0; en_run = 0; held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 0; prev_vld = 0; en_run = 0;
        continue;
      end
      if (tx_valid && !prev_vld && expect_start != 0) begin
        check(cyc == expect_start, "tx_start_cycle", cyc, expect_start);
        expect_start = 0;
      end
      if (tx_valid && stalled) check(tx_data == held, "tx_hold_stable", tx_data, held);
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) check(0, "tx_unexpected_byte", tx_data, 0);
        else begin
          e = exp_tx.pop_front();
          check(tx_data == e, "tx_byte", tx_data, e);
        end
        tx_xfers++;
        last_xfer_cyc = cyc;
      end
      stalled = tx_valid && !tx_ready;
      held = tx_data;
      prev_vld = tx_valid;
      if (frame_err) begin
        if (exp_err.size() == 0) check(0, "frame_err_unexpected", cyc, 0);
        else begin
          c = exp_err.pop_front();
          check(cyc == c, "frame_err_cycle", cyc, c);
        end
      end
      if (rx_drop) begin
        if (exp_drop.size() == 0) check(0, "rx_drop_unexpected", cyc, 0);
        else begin
          c = exp_drop.pop_front();
          check(cyc == c, "rx_drop_cycle", cyc, c);
        end
      end
      if (aes_enable) begin
        en_run++;
        en_total++;
      end else if (en_run != 0) begin
        check(en_run == L, "enable_length", en_run, L);
        en_run = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    last_cyc = cyc;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_err(input logic [7:0] b);
    send_byte(b);
    exp_err.push_back(last_cyc + 1);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [127:0] blk);
    send_byte(cmd);
    for (int i = 0; i < 16; i++) begin
      tick($urandom_range(0, 2));
      send_byte(blk[8*(15-i) +: 8]);
    end
  endtask

  task automatic send_key(input logic [127:0] k);
    send_frame(CMD_KEY_DEF, k);
    m_key = k;
    m_loaded = 1;
    check(aes_key == m_key, "key_commit", aes_key, m_key);
    check(key_loaded == 1'b1, "key_loaded", key_loaded, 1);
    check(busy == 1'b0, "busy_after_key", busy, 0);
  endtask

  task automatic wait_xfers(input int target);
    int n = 0;
    while (tx_xfers < target && n < 2000) begin tick(1); n++; end
    check(n < 2000, "tx_progress_timeout", n, 2000);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_tx.size() != 0 || busy) && n < 3000) begin tick(1); n++; end
    check(n < 3000, "tx_drain_timeout", n, 3000);
  endtask

  task automatic send_pt(input logic [127:0] p, input bit drop_run, input bit drop_tx);
    logic [127:0] c;
    send_frame(CMD_PT_DEF, p);
    c = core_model(m_key, p);
    for (int i = 0; i < 16; i++) exp_tx.push_back(c[8*(15-i) +: 8]);
    expect_start = last_cyc + L + 1;
    pt_start = expect_start;
    check(aes_plaintext == p, "pt_commit", aes_plaintext, p);
    if (drop_run) begin
      tick(2);
      send_byte(8'($urandom));
      exp_drop.push_back(last_cyc + 1);
    end
    if (drop_tx) begin
      wait_xfers(tx_xfers + 2);
      send_byte(8'($urandom));
      exp_drop.push_back(last_cyc + 1);
    end
  endtask

  initial begin : driver
    int en_before;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0;
    tick(3);
    check(tx_valid == 0, "reset_tx_valid", tx_valid, 0);
    check(aes_enable == 0, "reset_aes_enable", aes_enable, 0);
    check(key_loaded == 0, "reset_key_loaded", key_loaded, 0);
    check(busy == 0, "reset_busy", busy, 0);
    check(aes_key == 0, "reset_aes_key", aes_key, 0);
    check(aes_plaintext == 0, "reset_plaintext", aes_plaintext, 0);
    check(tx_data == 0, "reset_tx_data", tx_data, 0);
    check(frame_err == 0 && rx_drop == 0, "reset_pulses", {frame_err, rx_drop}, 0);
    reset = 1'b0;
    tick(1);

    // Plaintext command before any key
    en_before = en_total;
    send_err(CMD_PT_DEF);
    tick(20);
    check(en_total == en_before, "no_enable_without_key", en_total, en_before);
    check(busy == 0, "idle_after_pt_no_key", busy, 0);

    // Known vector, tx_ready held high
    send_key(K0);
    send_pt(P0, 0, 0);
    wait_done();
    check(last_xfer_cyc == pt_start + 15, "tx_back_to_back", last_xfer_cyc, pt_start + 15);

    // Partial key frame then silence
    send_byte(CMD_KEY_DEF);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    exp_err.push_back(last_cyc + T + 1);
    tick(T + 5);
    check(aes_key == m_key, "key_kept_after_timeout", aes_key, m_key);
    check(busy == 0, "idle_after_timeout", busy, 0);
    send_err(8'h00);
    tick(3);

    // Random frames with tx_ready stalls and dropped bytes
    stall_mode = 1;
    for (int t = 0; t < 6; t++) begin
      if (t == 0 || $urandom_range(0, 1) == 1)
        send_key({$urandom, $urandom, $urandom, $urandom});
      send_pt({$urandom, $urandom, $urandom, $urandom}, (t % 2) == 0, (t % 3) != 2);
      wait_done();
      tick($urandom_range(0, 3));
    end

    // Reset in the middle of TX
    send_pt({$urandom, $urandom, $urandom, $urandom}, 0, 0);
    wait_xfers(tx_xfers + 5);
    reset = 1'b1;
    tick(1);
    check(tx_valid == 0, "midtx_reset_tx_valid", tx_valid, 0);
    check(busy == 0, "midtx_reset_busy", busy, 0);
    check(key_loaded == 0, "midtx_reset_key_loaded", key_loaded, 0);
    exp_tx.delete();
    expect_start = 0;
    m_loaded = 0;
    reset = 1'b0;
    tick(2);

    en_before = en_total;
    send_err(CMD_PT_DEF);
    tick(20);
    check(en_total == en_before, "no_enable_after_reset", en_total, en_before);
    check(exp_err.size() == 0, "frame_err_all_seen", exp_err.size(), 0);
    check(exp_drop.size() == 0, "rx_drop_all_seen", exp_drop.size(), 0);
    check(exp_tx.size() == 0, "tx_all_seen", exp_tx.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
